// File: rtl/regfile_dump_pkg.sv
// Shared constants for the register-file dump sequencer: default sizes
// (common with the register file) and the FSM state encoding.
package regfile_dump_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/regfile_dump.sv
// Read-side sequencer: walks a register range through read port A1 and
// streams each value out over valid/ready, tagged with its register number.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    lo,
    input  logic [AW-1:0]    hi,
    output logic [AW-1:0]    ra,
    input  logic [WIDTH-1:0] rd,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic [AW-1:0]    hi_q, hi_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        hi_d    = hi_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_d    = hi;
                    ra_d    = lo;
                    busy_d  = 1'b1;
                    state_d = ADDR;
                end
            end
            // rd has had a full cycle to settle from ra; capture it now only.
            ADDR: begin
                data_d  = rd;
                addr_d  = ra_q;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (ra_q == hi_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        ra_d    = AW'(ra_q + 1'b1);
                        state_d = ADDR;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ra_q    <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign ra        = ra_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register file on the read port,
// expected beats queued at start and matched at each accepted transfer.
module tb_regfile_dump;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    lo, hi;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             done;

    // Register file model with write port 3 and combinational read port 1.
    logic [WIDTH-1:0] rf [32];
    logic             we3;
    logic [AW-1:0]    a3;
    logic [WIDTH-1:0] wd3;

    always @(posedge clk) if (we3) rf[a3] <= wd3;
    assign rd = rf[ra];

    regfile_dump #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi),
        .ra(ra), .rd(rd), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [AW+WIDTH-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfer monitor: scoreboard match, done counting, hold-under-stall.
    logic             hold_q = 1'b0;
    logic [WIDTH-1:0] hold_data;
    logic [AW-1:0]    hold_addr;

    always @(negedge clk) begin
        if (reset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_addr", out_addr, hold_addr);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {out_addr, out_data}, 0);
                end else begin
                    logic [AW+WIDTH-1:0] e;
                    e = sb.pop_front();
                    chk("beat_addr", out_addr, e[AW+WIDTH-1:WIDTH]);
                    chk("beat_data", out_data, e[WIDTH-1:0]);
                end
            end
            hold_q    = out_valid && !out_ready;
            hold_data = out_data;
            hold_addr = out_addr;
        end
    end

    task automatic push_range(input logic [AW-1:0] l, input logic [AW-1:0] h);
        int n;
        logic [AW-1:0] a;
        n = int'(AW'(h - l)) + 1;
        for (int k = 0; k < n; k++) begin
            a = AW'(l + AW'(k));
            sb.push_back({a, rf[a]});
        end
    endtask

    task automatic run_dump(input logic [AW-1:0] l, input logic [AW-1:0] h, input int exp_cyc);
        int cyc;
        int d0;
        push_range(l, h);
        d0 = done_cnt;
        lo = l; hi = h; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            if (busy) cyc++;
        end while (busy && cyc < 400);
        chk("dump_timeout", cyc < 400, 1);
        if (exp_cyc >= 0) chk("busy_cycles", cyc, exp_cyc);
        chk("done_count", done_cnt - d0, 1);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk(tag, w < 50, 1);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; lo = '0; hi = '0; out_ready = 1'b0;
        we3 = 1'b0; a3 = '0; wd3 = '0;

        // Preload every register through the write port.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            we3 = 1'b1;
            a3  = AW'(i);
            case (i)
                0:       wd3 = '0;
                1:       wd3 = 32'habcd_efab;
                2:       wd3 = 32'h0123_4567;
                3:       wd3 = 32'hcccc_cccc;
                default: wd3 = $urandom;
            endcase
        end
        @(posedge clk); #1;
        we3 = 1'b0;

        chk("rst_ra", ra, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic dump, ready held high.
        out_ready = 1'b1;
        run_dump(5'd1, 5'd3, 7);

        // Backpressure on the first beat.
        out_ready = 1'b0;
        fork
            run_dump(5'd2, 5'd3, -1);
            begin
                wait_valid("bp_wait");
                for (int i = 0; i < 5; i++) begin
                    chk("bp_valid", out_valid, 1);
                    chk("bp_addr", out_addr, 2);
                    chk("bp_data", out_data, 32'h0123_4567);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        // Wrapping and single-register ranges.
        run_dump(5'd30, 5'd1, 9);
        run_dump(5'd2, 5'd2, 3);
        run_dump(5'd0, 5'd31, 65);

        // Start re-asserted mid-dump with a different range.
        fork
            run_dump(5'd1, 5'd3, 7);
            begin
                repeat (3) @(posedge clk);
                #2;
                lo = '0; hi = '0; start = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        // Reset while stalled in SEND.
        out_ready = 1'b0;
        lo = 5'd1; hi = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("rst_wait");
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ra", ra, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_dump(5'd1, 5'd1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
